// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline stall / flush / redirect controller for a 5-stage core.
//
// Merges the per-stage stall requests into a 6-bit stop vector by priority
// (MEM > EX > ID > IF). It also accepts taken branches resolved in EX. An
// accepted branch flushes IF/ID and ID/EX. When IF has a fetch in flight, the
// redirect is held in DRAIN until that fetch returns. The returning fetch is
// discarded, and the PC is redirected in the same cycle.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build two saturating
// performance counters, which count stall cycles and accepted branches.
// Without it, both perf outputs are tied to zero and no counter flops exist.
//
// Ports
//   clk                 in   1   rising-edge clock
//   rst                 in   1   synchronous reset, active high
//   stallreq_if         in   1   IF fetch not ready
//   stallreq_id         in   1   ID hazard (e.g. load-use)
//   stallreq_ex         in   1   EX multi-cycle operation
//   stallreq_mem        in   1   MEM access busy
//   branch_flag         in   1   EX resolved a taken branch/jump
//   branch_target_addr  in   32  taken target
//   if_busy             in   1   IF has an outstanding fetch
//   stall               out  6   bit0 PC .. bit5 MEM/WB, 1 = stop
//   flush               out  1   kill IF/ID and ID/EX at the next edge
//   redirect_valid      out  1   PC loads redirect_pc at the next edge
//   redirect_pc         out  32  redirect target
//   discard_fetch       out  1   IF drops the returning fetch data
//   perf_stall_cycles   out  32  stall-cycle count
//   perf_flush_cnt      out  32  accepted-branch count
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  input  logic        if_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        discard_fetch,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] target_r;
  logic [31:0] target_next_s;
  logic [5:0]  stall_base_s;

  // Priority merge of stage stall requests. Each pattern stops the requesting
  // stage and everything upstream of it.
  always_comb begin
    stall_base_s = 6'b000000;
    if (stallreq_mem) begin
      stall_base_s = 6'b011111;
    end else if (stallreq_ex) begin
      stall_base_s = 6'b001111;
    end else if (stallreq_id) begin
      stall_base_s = 6'b000111;
    end else if (stallreq_if) begin
      stall_base_s = 6'b000011;
    end else begin
      stall_base_s = 6'b000000;
    end
  end

  // Next-state and output decode. Reset forces all control outputs quiet and
  // drops any pending redirect.
  always_comb begin
    state_next_s   = state_r;
    target_next_s  = target_r;
    stall          = stall_base_s;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = target_r;
    discard_fetch  = 1'b0;
    if (rst) begin
      stall         = 6'b000000;
      state_next_s  = IDLE;
      target_next_s = 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          // EX/MEM stalls freeze the branch in EX, so it is re-evaluated later.
          if (branch_flag && !stallreq_mem && !stallreq_ex) begin
            flush = 1'b1;
            stall = 6'b000000;
            if (!if_busy) begin
              redirect_valid = 1'b1;
              redirect_pc    = branch_target_addr;
              state_next_s   = IDLE;
            end else begin
              // The fetch in flight must return before the PC may move.
              target_next_s = branch_target_addr;
              state_next_s  = DRAIN;
            end
          end else begin
            state_next_s = IDLE;
          end
        end
        DRAIN: begin
          // Hold the PC and throw away the wrong-path fetch. Any new
          // branch_flag is ignored here.
          discard_fetch = 1'b1;
          stall         = stall_base_s | 6'b000001;
          if (!if_busy) begin
            redirect_valid = 1'b1;
            state_next_s   = IDLE;
          end else begin
            state_next_s = DRAIN;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State and latched-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      target_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_next_s;
      target_r <= target_next_s;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating performance counters. flush is high exactly in accepted-branch
  // cycles, so it doubles as the accept strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      if ((stall != 6'b000000) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_r;
  assign perf_flush_cnt    = flush_cnt_r;
`else
  assign perf_stall_cycles = 32'h0000_0000;
  assign perf_flush_cnt    = 32'h0000_0000;
`endif

endmodule
